// File: rtl/comm_mux_ctrl.sv
// Byte-command pin-mux controller: shadowed map/enable writes, readback, payload timeout.
// Optional build macro COMM_MUX_NAK_EN: unknown opcodes and payload timeouts answer 0xEE.
module comm_mux_ctrl #(
    parameter int N_OUT       = 16,
    parameter int N_IN        = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [N_IN-1:0]   in_pins,
    output wire logic [N_OUT-1:0] out_pins,
    output logic              busy
);

    localparam int SEL_W      = $clog2(N_IN);
    localparam int MAP_BITS   = N_OUT * SEL_W;
    localparam int MAP_BYTES  = (MAP_BITS + 7) / 8;
    localparam int MASK_BYTES = (N_OUT + 7) / 8;
    localparam int IN_BYTES   = (N_IN + 7) / 8;
    localparam int MAX_A      = (MAP_BYTES > MASK_BYTES) ? MAP_BYTES : MASK_BYTES;
    localparam int MAX_BYTES  = (MAX_A > IN_BYTES) ? MAX_A : IN_BYTES;
    localparam int SH_W       = MAX_BYTES * 8;
    localparam int CNT_W      = $clog2(MAX_BYTES + 1);
    localparam int TMO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [SH_W-1:0] MAP_MASK = SH_W'({MAP_BITS{1'b1}});
    localparam logic [SH_W-1:0] EN_MASK  = SH_W'({N_OUT{1'b1}});

    localparam logic [2:0] OP_RD_MAP = 3'd0;
    localparam logic [2:0] OP_WR_MAP = 3'd1;
    localparam logic [2:0] OP_RD_EN  = 3'd2;
    localparam logic [2:0] OP_WR_EN  = 3'd3;
    localparam logic [2:0] OP_RD_IN  = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        RX_PAYLOAD,
        COMMIT,
        TX_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [MAP_BITS-1:0] map_q, map_d;
    logic [N_OUT-1:0]    en_q, en_d;
    logic [SH_W-1:0]     shadow_q, shadow_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic                tgt_map_q, tgt_map_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [SH_W-1:0]     tx_shift_q, tx_shift_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;

    logic [SH_W-1:0]     map_ext, en_ext, in_ext;
    logic [SH_W-1:0]     shadow_map, shadow_en;
    logic                rd_hit;
    logic [SH_W-1:0]     rd_val;
    logic [CNT_W-1:0]    rd_len;
    logic                nak;

    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        en_d       = en_q;
        shadow_d   = shadow_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        tgt_map_d  = tgt_map_q;
        tmo_d      = tmo_q;
        tx_shift_d = tx_shift_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        rd_hit     = 1'b0;
        rd_val     = '0;
        rd_len     = CNT_W'(1);
        nak        = 1'b0;

        map_ext                 = '0;
        map_ext[MAP_BITS-1:0]   = map_q;
        en_ext                  = '0;
        en_ext[N_OUT-1:0]       = en_q;
        in_ext                  = '0;
        in_ext[N_IN-1:0]        = in_pins;
        shadow_map              = shadow_q & MAP_MASK;
        shadow_en               = shadow_q & EN_MASK;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (rx_valid) begin
                    if (rx_data[7:3] != 5'd0) begin
                        nak = 1'b1;
                    end else begin
                        case (rx_data[2:0])
                            OP_RD_MAP: begin
                                rd_hit = 1'b1;
                                rd_val = map_ext;
                                rd_len = CNT_W'(MAP_BYTES);
                            end
                            OP_RD_EN: begin
                                rd_hit = 1'b1;
                                rd_val = en_ext;
                                rd_len = CNT_W'(MASK_BYTES);
                            end
                            OP_RD_IN: begin
                                rd_hit = 1'b1;
                                rd_val = in_ext;
                                rd_len = CNT_W'(IN_BYTES);
                            end
                            OP_WR_MAP: begin
                                state_d   = RX_PAYLOAD;
                                shadow_d  = '0;
                                cnt_d     = '0;
                                len_d     = CNT_W'(MAP_BYTES);
                                tgt_map_d = 1'b1;
                            end
                            OP_WR_EN: begin
                                state_d   = RX_PAYLOAD;
                                shadow_d  = '0;
                                cnt_d     = '0;
                                len_d     = CNT_W'(MASK_BYTES);
                                tgt_map_d = 1'b0;
                            end
                            default: nak = 1'b1;
                        endcase
                    end
                end
            end

            RX_PAYLOAD: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    for (int b = 0; b < MAX_BYTES; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            shadow_d[b*8 +: 8] = rx_data;
                        end
                    end
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = COMMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (TIMEOUT_CYC != 0) begin
                    tmo_d = tmo_q + TMO_W'(1);
                    // The partial payload is dropped; live map/en were never touched.
                    if (tmo_d == TMO_W'(TIMEOUT_CYC)) begin
                        tmo_d    = '0;
                        shadow_d = '0;
                        state_d  = IDLE;
                        nak      = 1'b1;
                    end
                end
            end

            COMMIT: begin
                rd_hit = 1'b1;
                if (tgt_map_q) begin
                    map_d  = shadow_map[MAP_BITS-1:0];
                    rd_val = shadow_map;
                    rd_len = CNT_W'(MAP_BYTES);
                end else begin
                    en_d   = shadow_en[N_OUT-1:0];
                    rd_val = shadow_en;
                    rd_len = CNT_W'(MASK_BYTES);
                end
            end

            TX_RESP: begin
                if (tx_valid_q && tx_ready) begin
                    if (cnt_q == '0) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        tx_data_d  = tx_shift_q[7:0];
                        tx_shift_d = tx_shift_q >> 8;
                        cnt_d      = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (nak) begin
`ifdef COMM_MUX_NAK_EN
            rd_hit = 1'b1;
            rd_val = SH_W'(8'hEE);
            rd_len = CNT_W'(1);
`else
            state_d = IDLE;
`endif
        end

        // cnt_q counts the bytes still to send after the one on tx_data.
        if (rd_hit) begin
            tx_data_d  = rd_val[7:0];
            tx_shift_d = rd_val >> 8;
            cnt_d      = rd_len - CNT_W'(1);
            tx_valid_d = 1'b1;
            state_d    = TX_RESP;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            map_q      <= '0;
            en_q       <= '0;
            shadow_q   <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            tgt_map_q  <= 1'b0;
            tmo_q      <= '0;
            tx_shift_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            map_q      <= map_d;
            en_q       <= en_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            tgt_map_q  <= tgt_map_d;
            tmo_q      <= tmo_d;
            tx_shift_q <= tx_shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;

    // Out-of-range selects fall back to in_pins[0].
    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        logic [SEL_W-1:0] sel;
        assign sel = (32'(map_q[k*SEL_W +: SEL_W]) < N_IN) ? map_q[k*SEL_W +: SEL_W] : '0;
        assign out_pins[k] = en_q[k] ? in_pins[sel] : 1'bz;
    end

endmodule
